// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder: accepts one read or write at a time, stalls the
// requester while the access is in flight, and pulses Done a fixed LATENCY cycles later.
module stall_mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;

  logic [15:0] mem [2**DEPTH_LOG2];

  logic                  can_take, accept, reject, enter_resp;
  logic [DEPTH_LOG2-1:0] req_idx, cm_idx;
  logic [15:0]           cm_data;
  logic                  cm_wr;
  logic [15:0]           dout_d;
  logic                  done_d, err_d;

  // Address bits above the array index alias; they are deliberately dropped.
  logic unused_addr;
  if (DEPTH_LOG2 < 15) begin : g_addr_hi
    assign unused_addr = ^Addr[15:DEPTH_LOG2+1];
  end else begin : g_addr_full
    assign unused_addr = 1'b0;
  end

  assign req_idx  = Addr[DEPTH_LOG2:1];
  assign can_take = (state_q != StBusy);
  assign accept   = can_take & (Rd ^ Wr) & ~Addr[0];
  assign reject   = can_take & (Rd | Wr) & ~accept;
  assign Stall    = (state_q == StBusy);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      DataOut <= '0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      DataOut <= dout_d;
      Done    <= done_d;
      Err     <= err_d;
    end
  end

  // Array is not cleared by reset; a write pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cm_wr) begin
      mem[cm_idx] <= cm_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          state_d = (LATENCY > 1) ? StBusy : StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      cnt_d   = 4'(LATENCY - 1);
      idx_d   = req_idx;
      wdata_d = DataIn;
      wr_d    = Wr;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Output logic. With LATENCY=1 the accepting edge is also the commit edge, so the
  // commit uses the live request rather than the latched copy.
  always_comb begin
    enter_resp = (state_d == StResp);
    cm_idx     = accept ? req_idx : idx_q;
    cm_data    = accept ? DataIn : wdata_q;
    cm_wr      = accept ? Wr : wr_q;
    done_d     = enter_resp;
    err_d      = reject;
    dout_d     = '0;
    if (enter_resp && !cm_wr) begin
      dout_d = mem[cm_idx];
    end
  end

endmodule
